// File: rtl/uart_host_regs_if.sv
// Host bus between a processor-side master and the uart_host_regs register slave.
// The master drives the strobes, address and write data. The slave returns read data, rvalid and busy.
interface uart_host_regs_if;
  logic [2:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_busy;

  modport master (
    output bus_addr, bus_wr, bus_rd, bus_wdata,
    input  bus_rdata, bus_rvalid, bus_busy
  );

  modport slave (
    input  bus_addr, bus_wr, bus_rd, bus_wdata,
    output bus_rdata, bus_rvalid, bus_busy
  );
endinterface

// File: rtl/uart_host_regs.sv
// Register slave that drives the host side of uart_top: configuration, TX push, RX pop, and W1C interrupts.
// Define UART_HOST_REGS_IRQ_PULSE_EN to make irq a 1-cycle pulse on each newly enabled event instead of a level.
module uart_host_regs #(
  parameter int BAUD_RST      = 868,
  parameter int OVS_RST       = 174,
  parameter int TX_FIFO_DEPTH = 1024,
  parameter int RX_WAIT_MAX   = 4
) (
  input  logic        clk,
  input  logic        rst,
  uart_host_regs_if.slave bus,
  output logic        irq,
  output logic [12:0] baud_clk_cnt,
  output logic [9:0]  over_sample_clk_cnt,
  output logic [10:0] rx_int_holdoff_byte_time_cnt,
  output logic [10:0] rx_int_holdoff_byte_cnt,
  output logic        tx_en,
  output logic        rx_en,
  output logic [7:0]  tx_byte_host,
  output logic        tx_byte_host_dv,
  input  logic [7:0]  rx_byte_host,
  input  logic        rx_byte_host_dv,
  output logic        rx_byte_host_rd,
  input  logic [10:0] tx_byte_count,
  input  logic [10:0] rx_byte_count,
  input  logic [4:0]  int_status
);

  localparam logic [2:0] A_DATA = 3'd0, A_CTRL = 3'd1, A_BAUD = 3'd2, A_HOLD = 3'd3,
                         A_STAT = 3'd4, A_IER  = 3'd5, A_ISR  = 3'd6;
  localparam int WCW = (RX_WAIT_MAX > 1) ? $clog2(RX_WAIT_MAX) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RX_WAIT_MAX - 1);
  localparam logic [10:0]    TX_FULL   = 11'(TX_FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e         state_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           busy_q, rvalid_q, tx_dv_q, rx_rd_q, irq_q, tx_en_q, rx_en_q;
  logic [31:0]    rdata_q;
  logic [12:0]    baud_q;
  logic [9:0]     ovs_q;
  logic [10:0]    hold_time_q, hold_cnt_q;
  logic [7:0]     tx_byte_q;
  logic [5:0]     ier_q, isr_q, isr_d, isr_clr, irq_src;
  logic [4:0]     int_prev_q;
  logic           wr_ok, rd_ok, tx_ovf, irq_d;
  logic [31:0]    reg_rdata;
`ifdef UART_HOST_REGS_IRQ_PULSE_EN
  logic [5:0]     irq_src_prev_q;
`endif

  logic unused_wdata;
  assign unused_wdata = ^bus.bus_wdata[31:27];

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    wr_ok    = bus.bus_wr & ~busy_q;
    rd_ok    = bus.bus_rd & ~busy_q;
    tx_ovf   = wr_ok && (bus.bus_addr == A_DATA) && (tx_byte_count >= TX_FULL);
    isr_clr  = (wr_ok && bus.bus_addr == A_ISR) ? bus.bus_wdata[5:0] : 6'd0;
    // A new event in the same cycle as a W1C write keeps its bit set.
    isr_d    = (isr_q & ~isr_clr) | {tx_ovf, int_status & ~int_prev_q};
    irq_src  = isr_q & ier_q;
`ifdef UART_HOST_REGS_IRQ_PULSE_EN
    irq_d    = |(irq_src & ~irq_src_prev_q);
`else
    irq_d    = |irq_src;
`endif
    reg_rdata = 32'd0;
    case (bus.bus_addr)
      A_CTRL:  reg_rdata = {30'd0, rx_en_q, tx_en_q};
      A_BAUD:  reg_rdata = {6'd0, ovs_q, 3'd0, baud_q};
      A_HOLD:  reg_rdata = {5'd0, hold_cnt_q, 5'd0, hold_time_q};
      A_STAT:  reg_rdata = {5'd0, int_status, rx_byte_count, tx_byte_count};
      A_IER:   reg_rdata = {26'd0, ier_q};
      A_ISR:   reg_rdata = {26'd0, isr_q};
      default: reg_rdata = 32'd0;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      tx_dv_q     <= 1'b0;
      rx_rd_q     <= 1'b0;
      tx_byte_q   <= 8'd0;
      tx_en_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      baud_q      <= 13'(BAUD_RST);
      ovs_q       <= 10'(OVS_RST);
      hold_time_q <= 11'd0;
      hold_cnt_q  <= 11'd0;
      ier_q       <= 6'd0;
      isr_q       <= 6'd0;
      int_prev_q  <= 5'b00011;
      irq_q       <= 1'b0;
`ifdef UART_HOST_REGS_IRQ_PULSE_EN
      irq_src_prev_q <= 6'd0;
`endif
    end else begin
      tx_dv_q    <= 1'b0;
      rx_rd_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      int_prev_q <= int_status;
      isr_q      <= isr_d;
      irq_q      <= irq_d;
`ifdef UART_HOST_REGS_IRQ_PULSE_EN
      irq_src_prev_q <= irq_src;
`endif
      if (wr_ok) begin
        case (bus.bus_addr)
          A_DATA: if (!tx_ovf) begin
            tx_byte_q <= bus.bus_wdata[7:0];
            tx_dv_q   <= 1'b1;
          end
          A_CTRL: {rx_en_q, tx_en_q} <= bus.bus_wdata[1:0];
          A_BAUD: begin
            baud_q <= bus.bus_wdata[12:0];
            ovs_q  <= bus.bus_wdata[25:16];
          end
          A_HOLD: begin
            hold_time_q <= bus.bus_wdata[10:0];
            hold_cnt_q  <= bus.bus_wdata[26:16];
          end
          A_IER:   ier_q <= bus.bus_wdata[5:0];
          default: ;
        endcase
      end
      case (state_q)
        S_IDLE: if (rd_ok) begin
          if (bus.bus_addr != A_DATA) begin
            rdata_q  <= reg_rdata;
            rvalid_q <= 1'b1;
          end else if (rx_byte_count == 11'd0) begin
            rdata_q  <= 32'h0000_0100;
            rvalid_q <= 1'b1;
          end else begin
            rx_rd_q    <= 1'b1;
            busy_q     <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rx_byte_host_dv) begin
            rdata_q  <= {24'd0, rx_byte_host};
            rvalid_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            rdata_q  <= 32'h0000_0200;
            rvalid_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_rdata                = rdata_q;
  assign bus.bus_rvalid               = rvalid_q;
  assign bus.bus_busy                 = busy_q;
  assign irq                          = irq_q;
  assign baud_clk_cnt                 = baud_q;
  assign over_sample_clk_cnt          = ovs_q;
  assign rx_int_holdoff_byte_time_cnt = hold_time_q;
  assign rx_int_holdoff_byte_cnt      = hold_cnt_q;
  assign tx_en                        = tx_en_q;
  assign rx_en                        = rx_en_q;
  assign tx_byte_host                 = tx_byte_q;
  assign tx_byte_host_dv              = tx_dv_q;
  assign rx_byte_host_rd              = rx_rd_q;

endmodule

// File: doc/uart_host_regs.md
Name: uart_host_regs

Overview:
- Memory-mapped register slave that sits directly upstream of uart_top and drives its whole host-side interface.
- Drives baud and oversample counts, holdoff thresholds and enables. Pushes TX bytes and pops RX bytes with correct FIFO read latency.
- Latches interrupt events into a W1C status register and generates a single irq line to the processor.

Parameters:
- BAUD_RST, 868, reset value of baud_clk_cnt (100 MHz / 115200).
- OVS_RST, 174, reset value of over_sample_clk_cnt.
- TX_FIFO_DEPTH, 1024, usable TX FIFO entries; writes at or above this count are dropped.
- RX_WAIT_MAX, 4, cycles to wait for rx_byte_host_dv after a pop before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bus_addr  in  3  word address
- bus_wr  in  1  write strobe, 1 cycle
- bus_rd  in  1  read strobe, 1 cycle
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, valid with bus_rvalid
- bus_rvalid  out  1  read-data-valid pulse
- bus_busy  out  1  high while an RX pop is in flight
- irq  out  1  interrupt to processor
- baud_clk_cnt  out  13  to uart_top
- over_sample_clk_cnt  out  10  to uart_top
- rx_int_holdoff_byte_time_cnt  out  11  to uart_top
- rx_int_holdoff_byte_cnt  out  11  to uart_top
- tx_en, rx_en  out  1 each  to uart_top
- tx_byte_host  out  8  to uart_top
- tx_byte_host_dv  out  1  1-cycle push pulse
- rx_byte_host  in  8  from uart_top
- rx_byte_host_dv  in  1  from uart_top
- rx_byte_host_rd  out  1  1-cycle pop pulse
- tx_byte_count, rx_byte_count  in  11 each  from uart_top
- int_status  in  5  {time_coal, cnt_coal, rx_not_empty, tx_almost_empty, tx_empty}

Behaviour:
- Reset: all outputs 0, except baud_clk_cnt=BAUD_RST and over_sample_clk_cnt=OVS_RST. Holdoff counts 0, IER 0, ISR 0, FSM IDLE.
- Register map:
  - 0 DATA: W pushes [7:0]. R pops one byte.
  - 1 CTRL [0]=tx_en, [1]=rx_en (RW).
  - 2 BAUD [12:0] baud, [25:16] oversample (RW).
  - 3 HOLDOFF [10:0] byte_time, [26:16] byte_cnt (RW).
  - 4 STATUS RO {5'b0, int_status[4:0], rx_byte_count[10:0], tx_byte_count[10:0]}.
  - 5 IER [5:0] (RW).
  - 6 ISR [5:0]: W1C.
  - 7 reserved: reads 0, writes ignored.
- Unused read bits read 0.
- Writes take effect the cycle after bus_wr. A DATA write drives tx_byte_host/tx_byte_host_dv on the next cycle.
- TX overflow: a DATA write with tx_byte_count >= TX_FIFO_DEPTH is not pushed and sets ISR[5].
- Non-DATA reads: bus_rvalid and bus_rdata are asserted the cycle after bus_rd. bus_rdata holds its value until the next read.
- DATA read FSM:
  - IDLE: on bus_rd@DATA:
    - rx_byte_count==0: rvalid next cycle, rdata=0x100 (bit8 = empty), no pop.
    - otherwise: pulse rx_byte_host_rd, go to WAIT, bus_busy=1.
  - WAIT: on rx_byte_host_dv, rdata={24'b0, rx_byte_host}, rvalid=1 next cycle, return to IDLE.
  - WAIT timeout: after RX_WAIT_MAX cycles without dv, rdata=0x200 (bit9 = error), rvalid=1, return to IDLE.
- bus_rd or bus_wr while bus_busy is ignored; no side effect.
- ISR[4:0]: set on the rising edge of the corresponding int_status bit, using a registered previous value. Previous value resets to 5'b00011, so the empty TX after reset raises no event.
- ISR W1C precedence: set wins over clear in the same cycle.
- irq = |(ISR & IER), registered (1-cycle latency).
- Reset mid-WAIT: FSM returns to IDLE, no rvalid. A late rx_byte_host_dv is ignored.

Optional Feature:
- Macro UART_HOST_REGS_IRQ_PULSE_EN.
- Defined: irq is a 1-cycle pulse only when (ISR & IER) gains a new set bit compared with the previous cycle.
- Undefined: irq is the level |(ISR & IER) described above.

Test Plan:
- Reset, then read BAUD -> rvalid 1 cycle later, rdata=0x00AE0364. irq=0, tx_en=0.
- Write DATA 0x5A with tx_byte_count=3 -> next cycle tx_byte_host=0x5A, tx_byte_host_dv pulses 1 cycle.
- Write DATA with tx_byte_count=1024 -> no dv, ISR[5]=1. With IER=0x20, irq=1. Write ISR 0x20 -> ISR=0, irq=0.
- rx_byte_count=2, read DATA, model returns dv with 0xC3 one cycle after rd -> rvalid with rdata=0xC3, bus_busy high during the wait.
- Read DATA with rx_byte_count=0 -> rdata=0x100, no rx_byte_host_rd. Read DATA with a model that never returns dv -> rdata=0x200 after 4 wait cycles.
- IER=0x04, int_status[2] rises 0->1 -> ISR[2]=1, irq=1 (level). With UART_HOST_REGS_IRQ_PULSE_EN, irq is high for exactly 1 cycle.
